// File: rtl/blink_rtc_if.sv
// I/O register bus between the Z80-side decoder (master) and the RTC block (slave).
// The slave registers rdata and holds it between mapped reads.
interface blink_rtc_if;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output io_wr,
    output io_rd,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  io_wr,
    input  io_rd,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/blink_rtc.sv
// Blink real-time clock: tick/second/minute cascade, per-source status with
// masking, level irq, and a shadowed multi-byte minute read.
module blink_rtc #(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int SECS_PER_MIN  = 60,
  parameter int MIN_W         = 21
) (
  input  logic         mck,
  input  logic         rin,
  input  logic         rtc_hold,
  input  logic         gint,
  blink_rtc_if.slave   bus,
  output logic [2:0]   tsta,
  output logic         irq
);

  localparam int SHD_W = (MIN_W > 8) ? MIN_W - 8 : 1;

  localparam logic [7:0] A_TACK = 8'hB4;
  localparam logic [7:0] A_TMK  = 8'hB5;
  localparam logic [7:0] A_TIM0 = 8'hD0;
  localparam logic [7:0] A_TIM1 = 8'hD1;
  localparam logic [7:0] A_TIMM = 8'hD2;
  localparam logic [7:0] A_SHD0 = 8'hD3;
  localparam logic [7:0] A_SHD1 = 8'hD4;
  localparam logic [7:0] A_SHD2 = 8'hD5;

  logic [15:0]      tck_q,  tck_d;
  logic [7:0]       tim0_q, tim0_d;
  logic [5:0]       tim1_q, tim1_d;
  logic [MIN_W-1:0] timm_q, timm_d;
  logic [SHD_W-1:0] shd_q,  shd_d;
  logic [2:0]       tsta_q, tsta_d;
  logic [2:0]       tmk_q,  tmk_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             tck_term, tim0_term, tim1_term;
  logic [2:0]       set_vec;
  logic [2:0]       clr_vec;
  logic             wr_tack, wr_tmk, rd_timm;
  logic [SHD_W-1:0] shd_cap;
  logic [23:0]      shd_ext;

  assign tck_term  = (tck_q  == 16'(TICK_DIV - 1));
  assign tim0_term = (tim0_q == 8'(TICKS_PER_SEC - 1));
  assign tim1_term = (tim1_q == 6'(SECS_PER_MIN - 1));

  // Status sources are suppressed while the counters are held.
  assign set_vec = rtc_hold ? 3'b000
                 : {tck_term & tim0_term & tim1_term, tck_term & tim0_term, tck_term};

  assign wr_tack = bus.io_wr && (bus.addr == A_TACK);
  assign wr_tmk  = bus.io_wr && (bus.addr == A_TMK);
  assign rd_timm = bus.io_rd && (bus.addr == A_TIMM);
  assign clr_vec = wr_tack ? bus.wdata[2:0] : 3'b000;

  // Upper minute bits exist only when MIN_W exceeds one byte.
  generate
    if (MIN_W > 8) begin : g_shd
      assign shd_cap = timm_q[MIN_W-1:8];
      assign shd_ext = 24'(shd_q);
    end else begin : g_no_shd
      assign shd_cap = '0;
      assign shd_ext = '0;
    end
  endgenerate

  always_comb begin
    tck_d  = tck_q;
    tim0_d = tim0_q;
    tim1_d = tim1_q;
    timm_d = timm_q;
    shd_d  = rd_timm ? shd_cap : shd_q;
    if (rtc_hold) begin
      tck_d  = '0;
      tim0_d = '0;
      tim1_d = '0;
      timm_d = '0;
      shd_d  = '0;
    end else if (tck_term) begin
      tck_d  = '0;
      tim0_d = tim0_term ? 8'd0 : tim0_q + 8'd1;
      if (tim0_term) begin
        tim1_d = tim1_term ? 6'd0 : tim1_q + 6'd1;
        if (tim1_term) begin
          timm_d = timm_q + MIN_W'(1);
        end
      end
    end else begin
      tck_d = tck_q + 16'd1;
    end
  end

  // Set has priority over a same-cycle acknowledge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tsta
      assign tsta_d[gi] = set_vec[gi] | (tsta_q[gi] & ~clr_vec[gi]);
    end
  endgenerate

  assign tmk_d = wr_tmk ? bus.wdata[2:0] : tmk_q;

  always_comb begin
    rdata_d = rdata_q;
    if (bus.io_rd) begin
      case (bus.addr)
        A_TMK:   rdata_d = {5'b00000, tsta_q};
        A_TIM0:  rdata_d = tim0_q;
        A_TIM1:  rdata_d = {2'b00, tim1_q};
        A_TIMM:  rdata_d = timm_q[7:0];
        A_SHD0:  rdata_d = shd_ext[7:0];
        A_SHD1:  rdata_d = shd_ext[15:8];
        A_SHD2:  rdata_d = shd_ext[23:16];
        default: rdata_d = rdata_q;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      tck_q   <= '0;
      tim0_q  <= '0;
      tim1_q  <= '0;
      timm_q  <= '0;
      shd_q   <= '0;
      tsta_q  <= '0;
      tmk_q   <= '0;
      rdata_q <= '0;
    end else begin
      tck_q   <= tck_d;
      tim0_q  <= tim0_d;
      tim1_q  <= tim1_d;
      timm_q  <= timm_d;
      shd_q   <= shd_d;
      tsta_q  <= tsta_d;
      tmk_q   <= tmk_d;
      rdata_q <= rdata_d;
    end
  end

  assign tsta      = tsta_q;
  assign irq       = gint & |(tsta_q & tmk_q);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_blink_rtc.sv
// Directed bench for blink_rtc with small dividers (4 / 3 / 2, 9-bit minutes).
// Edge counts in comments are edges since the last reset release.
module tb_blink_rtc;

  logic       mck = 1'b0;
  logic       rin;
  logic       rtc_hold;
  logic       gint;
  logic [2:0] tsta;
  logic       irq;

  int tests = 0;
  int fails = 0;

  blink_rtc_if bus ();

  blink_rtc #(
    .TICK_DIV      (4),
    .TICKS_PER_SEC (3),
    .SECS_PER_MIN  (2),
    .MIN_W         (9)
  ) dut (
    .mck      (mck),
    .rin      (rin),
    .rtc_hold (rtc_hold),
    .gint     (gint),
    .bus      (bus.slave),
    .tsta     (tsta),
    .irq      (irq)
  );

  always #5 mck = ~mck;

  task automatic step(input int n);
    repeat (n) @(posedge mck);
    #1;
  endtask

  task automatic bus_op(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    bus.io_wr = wr;
    bus.io_rd = rd;
    bus.addr  = a;
    bus.wdata = d;
    step(1);
    bus.io_wr = 1'b0;
    bus.io_rd = 1'b0;
    $display("[TB] t=%0t wr=%0b rd=%0b addr=%02h wdata=%02h -> rdata=%02h tsta=%03b irq=%0b",
             $time, wr, rd, a, d, bus.rdata, tsta, irq);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    rin = 1'b1;
    step(1);
    rin = 1'b0;
  endtask

  initial begin
    rin       = 1'b1;
    rtc_hold  = 1'b0;
    gint      = 1'b0;
    bus.io_wr = 1'b0;
    bus.io_rd = 1'b0;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;

    // Reset state and basic cascade
    step(2);
    chk("rst_tsta", {5'b0, tsta}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_rdata", bus.rdata, 8'h00);
    rin = 1'b0;
    step(3);                                  // 3
    chk("pre_tick_tsta", {5'b0, tsta}, 8'h00);
    step(1);                                  // 4
    chk("tick_tsta", {5'b0, tsta}, 8'h01);
    bus_op(1'b0, 1'b1, 8'hD0, 8'h00);         // 5
    chk("tick_tim0", bus.rdata, 8'h01);
    step(7);                                  // 12
    chk("sec_tsta", {5'b0, tsta}, 8'h03);
    bus_op(1'b0, 1'b1, 8'hD1, 8'h00);         // 13
    chk("sec_tim1", bus.rdata, 8'h01);
    bus_op(1'b0, 1'b1, 8'hD0, 8'h00);         // 14
    chk("sec_tim0", bus.rdata, 8'h00);
    step(10);                                 // 24
    chk("min_tsta", {5'b0, tsta}, 8'h07);
    bus_op(1'b0, 1'b1, 8'hD2, 8'h00);         // 25
    chk("min_timm", bus.rdata, 8'h01);
    bus_op(1'b0, 1'b1, 8'hB5, 8'h00);         // 26
    chk("rd_tsta", bus.rdata, 8'h07);

    // Mask, irq and acknowledge
    release_reset();
    bus_op(1'b1, 1'b0, 8'hB5, 8'h02);         // 1
    gint = 1'b1;
    #1;
    chk("mask_irq0", {7'b0, irq}, 8'h00);
    step(3);                                  // 4
    chk("mask_tick_tsta", {5'b0, tsta}, 8'h01);
    chk("mask_tick_irq", {7'b0, irq}, 8'h00);
    step(7);                                  // 11
    chk("mask_presec_irq", {7'b0, irq}, 8'h00);
    step(1);                                  // 12
    chk("mask_sec_irq", {7'b0, irq}, 8'h01);
    bus_op(1'b1, 1'b0, 8'hB4, 8'h02);         // 13
    chk("ack_irq", {7'b0, irq}, 8'h00);
    chk("ack_tsta", {5'b0, tsta}, 8'h01);

    // Acknowledge versus same-cycle tick set
    bus_op(1'b1, 1'b0, 8'hB4, 8'h01);         // 14
    chk("ack0_tsta", {5'b0, tsta}, 8'h00);
    step(1);                                  // 15, tck at terminal count
    bus_op(1'b1, 1'b0, 8'hB4, 8'h01);         // 16
    chk("collide_tsta", {5'b0, tsta}, 8'h01);

    // Coherent multi-byte minute read
    gint = 1'b0;
    release_reset();
    step(6120);                               // timm = 0x0FF
    bus_op(1'b0, 1'b1, 8'hD2, 8'h00);         // 6121
    chk("coh_lo_ff", bus.rdata, 8'hFF);
    step(23);                                 // 6144, timm = 0x100
    bus_op(1'b0, 1'b1, 8'hD3, 8'h00);         // 6145
    chk("coh_stale_hi", bus.rdata, 8'h00);
    bus_op(1'b0, 1'b1, 8'hD2, 8'h00);         // 6146
    chk("coh_lo_00", bus.rdata, 8'h00);
    bus_op(1'b0, 1'b1, 8'hD3, 8'h00);         // 6147
    chk("coh_hi_01", bus.rdata, 8'h01);
    bus_op(1'b0, 1'b1, 8'hC0, 8'h00);
    chk("unmapped_hold", bus.rdata, 8'h01);
    bus_op(1'b0, 1'b1, 8'hD4, 8'h00);
    chk("coh_d4_zero", bus.rdata, 8'h00);

    // Counter hold
    release_reset();
    step(9);                                  // tim0 = 2, tck = 1
    bus_op(1'b0, 1'b1, 8'hD0, 8'h00);         // 10
    chk("hold_pre_tim0", bus.rdata, 8'h02);
    rtc_hold = 1'b1;
    step(1);
    chk("hold_tsta", {5'b0, tsta}, 8'h01);
    bus_op(1'b0, 1'b1, 8'hD0, 8'h00);
    chk("hold_tim0", bus.rdata, 8'h00);
    bus_op(1'b1, 1'b0, 8'hB4, 8'h07);
    chk("hold_ack_tsta", {5'b0, tsta}, 8'h00);
    rtc_hold = 1'b0;
    step(3);
    chk("unhold_pre_tsta", {5'b0, tsta}, 8'h00);
    step(1);
    chk("unhold_tick_tsta", {5'b0, tsta}, 8'h01);
    bus_op(1'b0, 1'b1, 8'hD0, 8'h00);
    chk("unhold_tim0", bus.rdata, 8'h01);

    // Same-cycle write and read, then reset mid-count
    bus_op(1'b1, 1'b1, 8'hB5, 8'h01);
    chk("wr_rd_rdata", bus.rdata, 8'h01);
    gint = 1'b1;
    #1;
    chk("wr_rd_irq", {7'b0, irq}, 8'h01);
    rin = 1'b1;
    step(1);
    chk("midrst_rdata", bus.rdata, 8'h00);
    chk("midrst_irq", {7'b0, irq}, 8'h00);
    chk("midrst_tsta", {5'b0, tsta}, 8'h00);
    rin = 1'b0;
    step(4);
    chk("postrst_tsta", {5'b0, tsta}, 8'h01);
    chk("postrst_irq_tmk0", {7'b0, irq}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
